// File: rtl/host_word_entry.sv
// host_word_entry: collects the host's secret word from keypad events,
// supports delete/enter, locks the word for the round and echoes progress
// on a 16-character host LCD row.
// Optional build macro: WORD_ENTRY_NODUP_EN (refuse repeated letters).
module host_word_entry #(
    parameter int         WORD_LEN = 5,
    parameter logic [7:0] KEY_DEL  = 8'h2A,
    parameter logic [7:0] KEY_ENT  = 8'h23
) (
    input  logic                  clk,
    input  logic                  nRst,
    input  logic                  key_valid,
    input  logic [7:0]            key_data,
    input  logic                  game_end,
    output logic [8*WORD_LEN-1:0] set_word,
    output logic                  word_valid,
    output logic                  word_load,
    output logic [3:0]            letter_count,
    output logic                  key_reject,
    output logic [127:0]          entry_row
);

    typedef enum logic [1:0] {
        ENTRY,
        FULL,
        LOCKED
    } state_t;

    localparam logic [3:0]  LEN    = 4'(WORD_LEN);
    localparam logic [47:0] PREFIX = "WORD: ";

    state_t                     state_q, state_d;
    logic [WORD_LEN-1:0][7:0]   word_q, word_d;
    logic [3:0]                 count_q, count_d;
    logic                       key_prev_q;
    logic                       load_q, load_d;
    logic                       reject_q, reject_d;

    logic                       key_evt;
    logic                       is_letter;
    logic [7:0]                 folded;
    logic                       is_dup;

    // A held key_valid only counts once: act on its rising edge.
    assign key_evt   = key_valid & ~key_prev_q;
    assign is_letter = ((key_data >= 8'h41) && (key_data <= 8'h5A)) ||
                       ((key_data >= 8'h61) && (key_data <= 8'h7A));
    assign folded    = key_data & 8'hDF;

`ifdef WORD_ENTRY_NODUP_EN
    // Flag a letter that already appears among the stored letters.
    always_comb begin
        is_dup = 1'b0;
        for (int i = 0; i < WORD_LEN; i++) begin
            if ((4'(i) < count_q) && (word_q[i] == folded)) begin
                is_dup = 1'b1;
            end
        end
    end
`else
    assign is_dup = 1'b0;
`endif

    // Next-state and buffer update; game_end overrides any key in the same cycle.
    always_comb begin
        state_d  = state_q;
        word_d   = word_q;
        count_d  = count_q;
        load_d   = 1'b0;
        reject_d = 1'b0;
        if (game_end) begin
            state_d = ENTRY;
            word_d  = '0;
            count_d = '0;
        end else if (key_evt) begin
            case (state_q)
                ENTRY: begin
                    if (key_data == KEY_DEL) begin
                        if (count_q != 4'd0) begin
                            for (int i = 0; i < WORD_LEN; i++) begin
                                if (4'(i) == (count_q - 4'd1)) begin
                                    word_d[i] = 8'h00;
                                end
                            end
                            count_d = count_q - 4'd1;
                        end else begin
                            reject_d = 1'b1;
                        end
                    end else if (is_letter && !is_dup) begin
                        for (int i = 0; i < WORD_LEN; i++) begin
                            if (4'(i) == count_q) begin
                                word_d[i] = folded;
                            end
                        end
                        count_d = count_q + 4'd1;
                        if (count_q == (LEN - 4'd1)) begin
                            state_d = FULL;
                        end
                    end else begin
                        reject_d = 1'b1;
                    end
                end
                FULL: begin
                    if (key_data == KEY_ENT) begin
                        state_d = LOCKED;
                        load_d  = 1'b1;
                    end else if (key_data == KEY_DEL) begin
                        word_d[WORD_LEN-1] = 8'h00;
                        count_d            = LEN - 4'd1;
                        state_d            = ENTRY;
                    end else begin
                        reject_d = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // State, buffer and pulse registers.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q    <= ENTRY;
            word_q     <= '0;
            count_q    <= '0;
            key_prev_q <= 1'b0;
            load_q     <= 1'b0;
            reject_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            count_q    <= count_d;
            key_prev_q <= key_valid;
            load_q     <= load_d;
            reject_q   <= reject_d;
        end
    end

    // Pack letters so letter 0 lands in the most significant byte.
    always_comb begin
        set_word = '0;
        for (int i = 0; i < WORD_LEN; i++) begin
            set_word[8*(WORD_LEN-1-i) +: 8] = word_q[i];
        end
    end

    // LCD row: prefix, letters or underscores, masked with '*' once locked.
    always_comb begin
        entry_row = {16{8'h20}};
        for (int c = 0; c < 6; c++) begin
            entry_row[127-8*c -: 8] = PREFIX[47-8*c -: 8];
        end
        for (int i = 0; i < WORD_LEN; i++) begin
            if (4'(i) < count_q) begin
                entry_row[127-8*(6+i) -: 8] = (state_q == LOCKED) ? 8'h2A : word_q[i];
            end else begin
                entry_row[127-8*(6+i) -: 8] = 8'h5F;
            end
        end
    end

    assign word_valid   = (state_q == LOCKED);
    assign word_load    = load_q;
    assign key_reject   = reject_q;
    assign letter_count = count_q;

endmodule

// File: doc/host_word_entry.md
Name: host_word_entry

Overview:
- Sits between the host-side keypad_fsm and Game_Logic/HostDisplay; sole driver of the secret word (setWord) for a round.
- Collects WORD_LEN letters from host keypad key events, supports delete and enter, then locks the word and issues a one-cycle load pulse.
- Stays locked for the round; game end clears it for the next word.
- Also drives a 16-character host LCD row echoing entry progress.

Parameters:
- WORD_LEN, 5, letters per secret word (1..10).
- KEY_DEL, 8'h2A, key code meaning delete last letter ('*').
- KEY_ENT, 8'h23, key code meaning confirm word ('#').

Ports:
- clk  input  1  system clock.
- nRst  input  1  asynchronous active-low reset.
- key_valid  input  1  one-cycle strobe from host keypad_fsm; key_data valid.
- key_data  input  8  ASCII key code.
- game_end  input  1  one-cycle pulse from Game_Logic at round end.
- set_word  output  8*WORD_LEN  secret word; letter 0 in the MSB byte, unfilled bytes 8'h00.
- word_valid  output  1  high while the word is locked.
- word_load  output  1  one-cycle pulse on the cycle word_valid first rises.
- letter_count  output  4  number of letters currently held.
- key_reject  output  1  one-cycle pulse for every refused key.
- entry_row  output  128  16 ASCII chars, char 0 at [127:120].

Behaviour:
- Reset (async, nRst=0): state ENTRY, set_word=0, letter_count=0, word_valid=0, word_load=0, key_reject=0.
- All register updates occur on the clk edge that samples key_valid/game_end; outputs change one cycle after the strobe.
- Letter classification:
  - 8'h41-8'h5A are letters.
  - 8'h61-8'h7A are letters, stored as uppercase (bit 5 cleared).
  - KEY_DEL and KEY_ENT are commands.
  - Any other code is rejected.
- State ENTRY (letter_count < WORD_LEN):
  - Letter: store at byte index letter_count, increment count; if the new count equals WORD_LEN, go to FULL.
  - KEY_DEL with count>0: clear the byte at count-1, decrement count.
  - KEY_DEL with count=0: key_reject.
  - KEY_ENT: key_reject (word incomplete).
  - Invalid code: key_reject.
- State FULL (letter_count = WORD_LEN):
  - KEY_ENT: go to LOCKED; word_valid=1 and word_load=1 for exactly one cycle.
  - KEY_DEL: clear the last byte, count=WORD_LEN-1, go to ENTRY.
  - Letter or invalid code: key_reject; buffer unchanged.
- State LOCKED:
  - All key_valid strobes are ignored silently (no key_reject).
  - set_word is held constant.
- game_end in any state: clear set_word and count, word_valid=0, go to ENTRY.
- game_end and key_valid in the same cycle: game_end wins, key dropped, no reject.
- entry_row:
  - Combinational from registers: "WORD: " (6 chars), then WORD_LEN chars (stored letter, or '_' 8'h5F if empty), remaining chars spaces (8'h20).
  - In LOCKED, letters are replaced by '*' (host screen privacy).
- key_reject and word_load are never asserted in the same cycle.
- Only the first key_valid of a multi-cycle-high strobe is acted on (edge-detect internally on key_valid).

Optional Feature:
- Macro: WORD_ENTRY_NODUP_EN.
- Defined: in ENTRY, a letter already present in the stored bytes [0..count-1] is refused with key_reject and the buffer is unchanged (duplicate compare is after uppercase folding).
- Undefined: duplicate letters are accepted normally.

Test Plan:
- Reset, keys 'H','E','L','L','O','#' -> set_word=40'h48454C4C4F, word_load one pulse one cycle after '#', word_valid=1, entry_row="WORD: *****     ".
- Keys 'a','b','*','c' -> letter_count=2, set_word=40'h4143000000, entry_row="WORD: AC___     ".
- Empty buffer, '*' then '#' then '7' -> three key_reject pulses, letter_count stays 0.
- Full word "ABCDE", then 'F' -> key_reject, buffer unchanged; then '*','Z','#' -> set_word=40'h414243445A, locked.
- Locked, keys 'Q','*' -> no change, no reject; game_end -> word_valid=0, set_word=0, count=0; game_end coincident with key 'X' -> X dropped.
- WORD_ENTRY_NODUP_EN defined: 'L','O','l' -> third key rejected, count=2; undefined -> count=3, set_word upper bytes 4C4F4C.
